// File: rtl/gs_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// gs_butterfly_pipe
//   Gentleman-Sande (inverse NTT) butterfly with a valid/ready handshake.
//     x = (a + b) mod q
//     y = ((a - b) mod q) * tf mod q
//   Optional per-operand halving multiplies both results by 2^-1 mod q.
//
//   Ranks: S1 add/sub with mod-q correction, S2 multiply by tf,
//   S3 exact mod-q reduction of the product; the output register applies
//   the halving. An operand set accepted at edge k shows out_valid=1 after
//   edge k+3 when the output is not back-pressured.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake for {a, b, tf, halve}
//   a, b, tf              operands, each < q
//   q                     odd modulus, static while work is in flight
//   halve                 1 = scale both results by 2^-1 mod q
//   out_valid / out_ready output handshake for {x, y}
//   x, y                  sum and twiddled-difference results
// ---------------------------------------------------------------------------
module gs_butterfly_pipe #(
    parameter int N = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] tf,
    input  logic [N-1:0] q,
    input  logic         halve,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x,
    output logic [N-1:0] y
);

    localparam int W2 = 2 * N;

    // One global advance enable: the whole pipe moves or the whole pipe
    // holds. Bubbles travel like data whenever the output is not stalled.
    logic adv;
    assign in_ready = ~(out_valid & ~out_ready);
    assign adv      = in_ready;

    // (v * 2^-1) mod q: odd values borrow one q so the shift is exact.
    function automatic logic [N-1:0] halve_mod(input logic [N-1:0] v,
                                               input logic         h,
                                               input logic [N-1:0] m);
        return h ? N'(({1'b0, v} + (v[0] ? {1'b0, m} : '0)) >> 1) : v;
    endfunction

    // ---------------- S1: modular add / subtract ----------------
    logic [N:0]   q_ext;
    logic [N:0]   sum_raw;
    logic [N-1:0] sum_mod;
    logic [N-1:0] diff_mod;

    assign q_ext    = {1'b0, q};
    assign sum_raw  = {1'b0, a} + {1'b0, b};
    assign sum_mod  = N'((sum_raw >= q_ext) ? (sum_raw - q_ext) : sum_raw);
    // a < b wraps by adding q; the result is then below q and fits N bits.
    assign diff_mod = N'((a >= b) ? ({1'b0, a} - {1'b0, b})
                                  : ({1'b0, a} + q_ext - {1'b0, b}));

    logic [N-1:0] s1_sum, s1_diff, s1_tf;
    logic         s1_halve, s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum   <= '0;
            s1_diff  <= '0;
            s1_tf    <= '0;
            s1_halve <= 1'b0;
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_sum   <= sum_mod;
            s1_diff  <= diff_mod;
            s1_tf    <= tf;
            s1_halve <= halve;
            s1_valid <= in_valid;
        end
    end

    // ---------------- S2: full-width product ----------------
    logic [W2-1:0] prod_c;
    assign prod_c = W2'(s1_diff) * W2'(s1_tf);

    logic [N-1:0]  s2_sum;
    logic [W2-1:0] s2_prod;
    logic          s2_halve, s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum   <= '0;
            s2_prod  <= '0;
            s2_halve <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_sum   <= s1_sum;
            s2_prod  <= prod_c;
            s2_halve <= s1_halve;
            s2_valid <= s1_valid;
        end
    end

    // ---------------- S3: exact reduction into [0, q-1] ----------------
    // q is a run-time input, so a general remainder is used; the result is
    // below q and therefore fits N bits.
    logic [N-1:0] red_c;
    assign red_c = N'(s2_prod % W2'(q));

    logic [N-1:0] s3_sum, s3_red;
    logic         s3_halve, s3_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_sum   <= '0;
            s3_red   <= '0;
            s3_halve <= 1'b0;
            s3_valid <= 1'b0;
        end else if (adv) begin
            s3_sum   <= s2_sum;
            s3_red   <= red_c;
            s3_halve <= s2_halve;
            s3_valid <= s2_valid;
        end
    end

    // ---------------- output register: halving ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            x         <= halve_mod(s3_sum, s3_halve, q);
            y         <= halve_mod(s3_red, s3_halve, q);
            out_valid <= s3_valid;
        end
    end

endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_gs_butterfly_pipe
//   Directed bench for gs_butterfly_pipe. A plain-arithmetic model queues the
//   expected {x, y} for every accepted operand set; a negedge monitor checks
//   every valid output, the in_ready rule and (where enabled) the latency.
//   Directed cases also compare against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_gs_butterfly_pipe;

    localparam int N = 17;
    localparam int Q = 12289;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic [N-1:0] tf        = '0;
    logic [N-1:0] q         = N'(Q);
    logic         halve     = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] x;
    logic [N-1:0] y;

    gs_butterfly_pipe #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .tf(tf), .q(q), .halve(halve),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint ex;
        longint ey;
        int     acc;
        bit     seen;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    int   out_cnt  = 0;
    bit   lat_chk  = 1'b0;

    always @(posedge clk) edge_cnt++;

    // Reference: straight modular arithmetic on wide integers.
    function automatic exp_t model(longint av, longint bv, longint tv,
                                   longint qv, bit h);
        exp_t   e;
        longint s, d, p;
        s = (av + bv) % qv;
        d = (av - bv + qv) % qv;
        p = (d * tv) % qv;
        if (h) begin
            s = (s % 2 == 0) ? s / 2 : (s + qv) / 2;
            p = (p % 2 == 0) ? p / 2 : (p + qv) / 2;
        end
        e.ex = s; e.ey = p; e.acc = 0; e.seen = 1'b0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b, required %b", in_ready,
                         !(out_valid && !out_ready));
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: x=%0d y=%0d with nothing in flight", x, y);
                end else begin
                    if (x !== N'(exp_q[0].ex) || y !== N'(exp_q[0].ey)) begin
                        errors++;
                        $display("FAIL result: got x=%0d y=%0d, required x=%0d y=%0d",
                                 x, y, exp_q[0].ex, exp_q[0].ey);
                    end
                    if (lat_chk && !exp_q[0].seen) begin
                        checks++;
                        if (edge_cnt - exp_q[0].acc != 3) begin
                            errors++;
                            $display("FAIL latency: got %0d, required 3",
                                     edge_cnt - exp_q[0].acc);
                        end
                    end
                    exp_q[0].seen = 1'b1;
                    if (out_ready) begin
                        out_cnt++;
                        $display("out #%0d x=%0d y=%0d", out_cnt, x, y);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                e     = model(a, b, tf, q, halve);
                e.acc = edge_cnt + 1;
                exp_q.push_back(e);
            end
        end
    end

    // Present one operand set and hold it until accepted.
    task automatic send(input int av, input int bv, input int tv, input bit h);
        a = N'(av); b = N'(bv); tf = N'(tv); halve = h;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no acceptance, required in_ready within 50 cycles");
        in_valid = 1'b0;
    endtask

    // One isolated set checked against literal expectations.
    task automatic single(input string nm, input int av, input int bv,
                          input int tv, input bit h, input int ex, input int ey);
        lat_chk = 1'b1;
        send(av, bv, tv, h);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_x"}, 64'(x), 64'(ex));
        chk({nm, "_y"}, 64'(y), 64'(ey));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_x", 64'(x), 64'd0);
        chk("reset_y", 64'(y), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed literal cases.
        single("basic",    5,     3,     2,     1'b0, 8,     4);
        single("wrap",     3,     5,     1,     1'b0, 8,     12287);
        single("halve_od", 5,     2,     1,     1'b1, 6148,  6146);
        single("halve_ev", 4,     2,     3,     1'b1, 3,     3);
        single("max_op",   12288, 12288, 12288, 1'b0, 12287, 0);
        single("max_tf",   12288, 0,     12288, 1'b0, 12288, 1);

        // Eight back-to-back sets, output stalled for cycles 4..6.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send((i * 1543 + 7) % Q, (i * 4099 + 11) % Q,
                         (i * 977 + 3) % Q, i[0]);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 4 && c <= 6);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("stream_drained", 64'(exp_q.size()), 64'd0);
        chk("stream_count", 64'(out_cnt), 64'd14);

        // Reset with three sets in flight and one on the output.
        send(100, 200, 300, 1'b0);
        send(400, 500, 600, 1'b1);
        send(700, 800, 900, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_x", 64'(x), 64'd0);
        chk("midrst_y", 64'(y), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        single("post_rst", 7, 9, 5, 1'b0, 16, 12279);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
